// File: rtl/lbm_rng_pkg.sv
// -----------------------------------------------------------------------------
// lbm_rng_pkg
// Shared definitions for the LBM random-number stream: LFSR width and taps,
// the scrambler3 bit permutation, the LFSR next-state function and the
// descrambler checker state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package lbm_rng_pkg;

   localparam int LFSR_W = 25;

   // Feedback taps of x^25 + x^22 + 1.
   localparam int TAP_HI = 24;
   localparam int TAP_LO = 21;

   // scrambler3 moves bit SCRAMBLE_MAP[i] of a word to bit i. The descrambler
   // therefore sends in bit i back to out bit SCRAMBLE_MAP[i].
   localparam int SCRAMBLE_MAP [0:LFSR_W-1] = '{
      24,  3, 14, 19, 13,  7,  1,  5, 22,  8,  2,  4, 12,
      10,  0, 11, 16, 17,  9, 18, 23, 15,  6, 20, 21
   };

   typedef enum logic {
      SEEK  = 1'b0,
      TRACK = 1'b1
   } chk_state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
      return {x[LFSR_W-2:0], x[TAP_HI] ^ x[TAP_LO]};
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Follows descrambled words against a locally regenerated LFSR sequence.
// SEEK waits for a non-zero word to seed the expectation; TRACK compares every
// accepted word, counts mismatches and falls back to SEEK after LOSS_THRESH
// consecutive misses.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_accept       a word is accepted this cycle
//   i_word         descrambled word being accepted
//   i_err_clr      clear the error counter (wins over an increment)
//   o_locked       in TRACK and the last compared word matched
//   o_err_cnt      saturating mismatch count
// -----------------------------------------------------------------------------
module lfsr_checker
   import lbm_rng_pkg::*;
#(
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_accept,
   input  logic [LFSR_W-1:0] i_word,
   input  logic              i_err_clr,
   output logic              o_locked,
   output logic [ERR_W-1:0]  o_err_cnt
);

   localparam int MISS_W = $clog2(LOSS_THRESH + 1);

   chk_state_e        r_state,    w_state_next;
   logic [LFSR_W-1:0] r_expected, w_expected_next;
   logic [MISS_W-1:0] r_miss,     w_miss_next;
   logic              r_locked,   w_locked_next;
   logic [ERR_W-1:0]  r_err_cnt,  w_err_cnt_next;
   logic              w_err_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= SEEK;
         r_expected <= '0;
         r_miss     <= '0;
         r_locked   <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_expected <= w_expected_next;
         r_miss     <= w_miss_next;
         r_locked   <= w_locked_next;
         r_err_cnt  <= w_err_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_expected_next = r_expected;
      w_miss_next     = r_miss;
      w_locked_next   = r_locked;
      w_err_inc       = 1'b0;

      if (i_accept) begin
         unique case (r_state)
            SEEK: begin
               w_locked_next = 1'b0;
               // All-zero is the LFSR lockup state and cannot seed a sequence.
               if (i_word != '0) begin
                  w_state_next    = TRACK;
                  w_expected_next = lfsr_next(i_word);
                  w_miss_next     = '0;
               end
            end
            TRACK: begin
               if (i_word == r_expected) begin
                  w_expected_next = lfsr_next(i_word);
                  w_miss_next     = '0;
                  w_locked_next   = 1'b1;
               end else begin
                  // Keep stepping the local sequence so a single corrupted
                  // word does not desynchronise the checker.
                  w_err_inc       = 1'b1;
                  w_expected_next = lfsr_next(r_expected);
                  w_locked_next   = 1'b0;
                  if (r_miss == MISS_W'(LOSS_THRESH - 1)) begin
                     w_state_next = SEEK;
                     w_miss_next  = '0;
                  end else begin
                     w_miss_next  = r_miss + 1'b1;
                  end
               end
            end
            default: w_state_next = SEEK;
         endcase
      end

      w_err_cnt_next = r_err_cnt;
      if (i_err_clr) begin
         w_err_cnt_next = '0;
      end else if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
         w_err_cnt_next = r_err_cnt + 1'b1;
      end
   end

   assign o_locked  = r_locked;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/descrambler3.sv
// -----------------------------------------------------------------------------
// descrambler3
// Inverts the scrambler3 bit permutation on each accepted 25-bit RNG word and
// registers it into a single-stage valid/ready output buffer (1-cycle latency,
// full throughput). With DESCRAMBLE_CHECK_EN defined, an lfsr_checker tracks
// the recovered words against the x^25+x^22+1 sequence; otherwise locked and
// err_cnt are tied to 0 and err_clr is ignored.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_ready/in_data  scrambled word input handshake
//   out_valid/out_ready/out_data descrambled word output handshake
//   err_clr                  clear err_cnt
//   locked                   checker in TRACK with last word matching
//   err_cnt                  saturating mismatch count (ERR_W bits)
// -----------------------------------------------------------------------------
module descrambler3
   import lbm_rng_pkg::*;
#(
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [LFSR_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [LFSR_W-1:0] out_data,
   input  logic                     err_clr,
   output logic                     locked,
   output logic [ERR_W-1:0]         err_cnt
);

   logic [LFSR_W-1:0] w_descr;
   logic              w_accept;
   logic              r_out_valid;
   logic [LFSR_W-1:0] r_out_data;

   genvar gi;
   generate
      for (gi = 0; gi < LFSR_W; gi++) begin : g_unmap
         assign w_descr[SCRAMBLE_MAP[gi]] = in_data[gi];
      end
   endgenerate

   // The buffer can take a new word whenever it is empty or being drained.
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_descr;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef DESCRAMBLE_CHECK_EN
   lfsr_checker #(
      .LOSS_THRESH (LOSS_THRESH),
      .ERR_W       (ERR_W)
   ) u_checker (
      .clk       (clk),
      .reset     (reset),
      .i_accept  (w_accept),
      .i_word    (w_descr),
      .i_err_clr (err_clr),
      .o_locked  (locked),
      .o_err_cnt (err_cnt)
   );
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign locked  = 1'b0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_descrambler3.sv
// -----------------------------------------------------------------------------
// tb_descrambler3
// Self-checking bench for descrambler3. A behavioural reference (inverse bit
// table, arithmetic LFSR, plain checker model) predicts every output each
// cycle; directed phases cover bit walk, back-pressure, lock/error/loss,
// zero seed, clear-vs-increment, saturation and mid-stream reset, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_descrambler3;

   localparam int LOSS = 4;
   localparam int EW   = 6;
   localparam int EMAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          err_clr = 1'b0;
   logic [24:0]   in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [24:0]   out_data;
   logic          locked;
   logic [EW-1:0] err_cnt;

   always #5 clk = ~clk;

   descrambler3 #(
      .LOSS_THRESH (LOSS),
      .ERR_W       (EW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_clr   (err_clr),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   // SRC[o] = input bit that lands on output bit o.
   int SRC [25] = '{14, 6, 10, 1, 11, 7, 22, 5, 9, 18, 13, 15, 12,
                    4, 2, 21, 16, 17, 19, 3, 23, 24, 8, 20, 0};

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   bit          m_valid = 1'b0;
   logic [24:0] m_data  = '0;
   bit          m_track = 1'b0;
   logic [24:0] m_exp   = '0;
   int          m_miss  = 0;
   bit          m_lock  = 1'b0;
   int          m_err   = 0;

   logic [24:0] seq = 25'h1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] ref_desc(input logic [24:0] x);
      logic [24:0] r;
      for (int o = 0; o < 25; o++) r[o] = x[SRC[o]];
      return r;
   endfunction

   function automatic logic [24:0] ref_scr(input logic [24:0] d);
      logic [24:0] r;
      for (int o = 0; o < 25; o++) r[SRC[o]] = d[o];
      return r;
   endfunction

   function automatic logic [24:0] ref_nxt(input logic [24:0] x);
      logic [24:0] fb;
      fb = (x >> 24) ^ (x >> 21);
      return (x << 1) | {24'b0, fb[0]};
   endfunction

   task automatic cycle(input bit rst, input bit iv, input logic [24:0] data,
                        input bit ordy, input bit clr);
      bit          exp_rdy, acc, inc, e_lock;
      logic [24:0] d;
      int          e_err;
      @(negedge clk);
      reset = rst; in_valid = iv; in_data = data; out_ready = ordy; err_clr = clr;
      #1;
      exp_rdy = !m_valid || ordy;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = iv && exp_rdy && !rst;
      d   = ref_desc(data);
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = '0; m_track = 0; m_exp = '0; m_miss = 0; m_lock = 0; m_err = 0;
      end else begin
         inc = 0;
         if (acc) begin
            if (!m_track) begin
               m_lock = 0;
               if (d != 0) begin m_track = 1; m_exp = ref_nxt(d); m_miss = 0; end
            end else if (d == m_exp) begin
               m_exp = ref_nxt(d); m_miss = 0; m_lock = 1;
            end else begin
               inc = 1; m_exp = ref_nxt(m_exp); m_lock = 0; m_miss++;
               if (m_miss == LOSS) begin m_track = 0; m_miss = 0; end
            end
         end
         if (clr) m_err = 0;
         else if (inc && m_err < EMAX) m_err++;
         if (acc) begin m_valid = 1; m_data = d; end
         else if (ordy) m_valid = 0;
      end
`ifdef DESCRAMBLE_CHECK_EN
      e_lock = m_lock; e_err = m_err;
`else
      e_lock = 0; e_err = 0;
`endif
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("locked", 32'(locked), 32'(e_lock));
      check("err_cnt", 32'(err_cnt), 32'(e_err));
      if (acc)
         $display("xfer in=%h out=%h locked=%0b err_cnt=%0d", data, out_data, locked, err_cnt);
   endtask

   task automatic send(input bit corrupt, input bit clr);
      logic [24:0] d;
      logic [31:0] r;
      d = seq;
      if (corrupt) begin
         r = 32'($urandom_range(24, 0));
         d = d ^ (25'h1 << r[4:0]);
      end
      cycle(0, 1, ref_scr(d), 1, clr);
      seq = ref_nxt(seq);
   endtask

   task automatic do_reset();
      cycle(1, 0, '0, 1, 0);
      cycle(1, 0, '0, 1, 0);
   endtask

   initial begin
      logic [24:0] w1, w2, pend;
      logic [31:0] r;
      bit          have_pend, iv, ordy, clr, crp;

      do_reset();
      cycle(0, 0, '0, 1, 0);

      // Bit walk with two literal spot checks.
      for (int b = 0; b < 25; b++) begin
         cycle(0, 1, 25'h1 << b, 1, 0);
         if (b == 0) check("walk_bit0", 32'(out_data), 32'h0100_0000);
         if (b == 1) check("walk_bit1", 32'(out_data), 32'h0000_0008);
      end
      do_reset();

      // Back-pressure: word 2 waits until out_ready rises.
      w1 = ref_scr(25'h0ABCDEF);
      w2 = ref_scr(25'h1234567);
      cycle(0, 1, w1, 0, 0);
      cycle(0, 1, w2, 0, 0);
      check("bp_hold", 32'(out_data), 32'h00ABCDEF);
      cycle(0, 1, w2, 1, 0);
      check("bp_word2", 32'(out_data), 32'h01234567);
      cycle(0, 0, '0, 1, 0);

      // Lock on the sequence seeded with 1.
      do_reset();
      seq = 25'h1;
      for (int k = 0; k < 10; k++) send(0, 0);
      // Single error then relock; then four errors force SEEK.
      send(1, 0);
      send(0, 0);
      for (int k = 0; k < 4; k++) send(1, 0);
      send(0, 0);
      send(0, 0);

      // All-zero word in SEEK is ignored.
      do_reset();
      cycle(0, 1, '0, 1, 0);
      seq = 25'h1;
      send(0, 0);
      send(0, 0);
      send(0, 0);
      // Clear wins over a same-cycle mismatch.
      send(1, 0);
      send(0, 0);
      send(1, 1);
      send(0, 0);

      // Saturation via a stream of random words.
      for (int k = 0; k < 90; k++) begin
         r = $urandom;
         cycle(0, 1, r[24:0], 1, 0);
      end
      cycle(0, 0, '0, 1, 1);

      // Reset while a word is held in the output register.
      r = $urandom;
      cycle(0, 1, r[24:0], 0, 0);
      cycle(1, 1, r[24:0], 0, 0);
      r = $urandom;
      seq = r[24:0] | 25'h1;
      for (int k = 0; k < 4; k++) send(0, 0);

      // Randomized traffic.
      have_pend = 0;
      pend = '0;
      for (int k = 0; k < 400; k++) begin
         if (!have_pend) begin
            pend = seq;
            r = $urandom;
            crp = (r[2:0] == 3'd0);
            if (crp) pend = pend ^ (25'h1 << r[7:3] % 25);
            seq = ref_nxt(seq);
            pend = ref_scr(pend);
            have_pend = 1;
         end
         r = $urandom;
         iv   = r[0] | r[1];
         ordy = r[2] | r[3];
         clr  = (r[8:4] == 5'd0);
         cycle(0, iv, pend, ordy, clr);
         if (iv && (!m_valid || ordy) && m_data == ref_desc(pend)) have_pend = 0;
         else if (iv && m_valid && m_data == ref_desc(pend) && ordy) have_pend = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
